// File: rtl/func_sweep.sv
// func_sweep: sweeps a 2-input programmable logic unit through all 16 functions x 4 operand pairs and checks z.
// Latency: each vector is held SETTLE cycles; a full sweep takes 64*SETTLE cycles after start, then a one-cycle done pulse.
// Backpressure: none; start is accepted only in IDLE. Optional FUNC_SWEEP_HALT_EN stops on the first mismatch and reports fail_sel/fail_xy.
module func_sweep #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  sel,
    output logic        x,
    output logic        y,
    input  logic        z,
    output logic        busy,
    output logic        done,
    output logic [6:0]  err_count,
    output logic [15:0] fail_mask
`ifdef FUNC_SWEEP_HALT_EN
    ,
    output logic [3:0]  fail_sel,
    output logic [1:0]  fail_xy
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  xy_q, xy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  err_q, err_d;
    logic [15:0] mask_q, mask_d;
`ifdef FUNC_SWEEP_HALT_EN
    logic [3:0]  fail_sel_q, fail_sel_d;
    logic [1:0]  fail_xy_q, fail_xy_d;
`endif

    // Truth-table row for operands {x,y}: index 00 reads sel[3], 11 reads sel[0].
    logic [1:0] bit_idx;
    logic       exp_z;
    logic       mismatch;
    logic       last_vec;

    always_comb begin
        bit_idx  = 2'd3 - xy_q;
        exp_z    = sel_q[bit_idx];
        mismatch = (z != exp_z);
        last_vec = (sel_q == 4'hF) && (xy_q == 2'b11);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        xy_d    = xy_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
`ifdef FUNC_SWEEP_HALT_EN
        fail_sel_d = fail_sel_q;
        fail_xy_d  = fail_xy_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sel_d   = 4'd0;
                    xy_d    = 2'b00;
                    cnt_d   = 4'd0;
                    err_d   = 7'd0;
                    mask_d  = 16'h0000;
`ifdef FUNC_SWEEP_HALT_EN
                    fail_sel_d = 4'd0;
                    fail_xy_d  = 2'b00;
`endif
                end
            end
            RUN: begin
                if (cnt_q < SETTLE_M1) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd0;
                    if (mismatch) begin
                        err_d  = err_q + 7'd1;
                        mask_d = mask_q | (16'h0001 << sel_q);
                    end
`ifdef FUNC_SWEEP_HALT_EN
                    if (mismatch) begin
                        // Freeze sel/x/y on the failing vector so it can be probed on the board.
                        state_d    = DONE;
                        fail_sel_d = sel_q;
                        fail_xy_d  = xy_q;
                    end else if (last_vec) begin
                        state_d = DONE;
                    end else begin
                        xy_d = xy_q + 2'd1;
                        if (xy_q == 2'b11) begin
                            sel_d = sel_q + 4'd1;
                        end
                    end
`else
                    if (last_vec) begin
                        state_d = DONE;
                    end else begin
                        xy_d = xy_q + 2'd1;
                        if (xy_q == 2'b11) begin
                            sel_d = sel_q + 4'd1;
                        end
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 4'd0;
            xy_q    <= 2'b00;
            cnt_q   <= 4'd0;
            err_q   <= 7'd0;
            mask_q  <= 16'h0000;
`ifdef FUNC_SWEEP_HALT_EN
            fail_sel_q <= 4'd0;
            fail_xy_q  <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            xy_q    <= xy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
`ifdef FUNC_SWEEP_HALT_EN
            fail_sel_q <= fail_sel_d;
            fail_xy_q  <= fail_xy_d;
`endif
        end
    end

    always_comb begin
        sel       = sel_q;
        x         = xy_q[1];
        y         = xy_q[0];
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        err_count = err_q;
        fail_mask = mask_q;
`ifdef FUNC_SWEEP_HALT_EN
        fail_sel  = fail_sel_q;
        fail_xy   = fail_xy_q;
`endif
    end

endmodule

// File: tb/tb_func_sweep.sv
// Bench for func_sweep: two instances (SETTLE=1 and SETTLE=3) driving a behavioural function unit whose fault mode is selectable.
module tb_func_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic        z1, z3;
    logic [3:0]  sel1, sel3;
    logic        x1, y1, x3, y3;
    logic        busy1, busy3, done1, done3;
    logic [6:0]  err1, err3;
    logic [15:0] mask1, mask3;
`ifdef FUNC_SWEEP_HALT_EN
    logic [3:0]  fail_sel1, fail_sel3;
    logic [1:0]  fail_xy1, fail_xy3;
`endif
    int mode1 = 0;
    int mode3 = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          len;
        logic [6:0]  err;
        logic [15:0] mask;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Reference 2-input function unit: z = f_sel(x,y) with row xy=00 taken from sel[3].
    function automatic logic ref_z(logic [3:0] s, logic a, logic b);
        return a ? (b ? s[0] : s[1]) : (b ? s[2] : s[3]);
    endfunction

    // mode 0: correct unit, 1: z stuck at 0, 2: z inverted
    function automatic logic unit_z(int m, logic [3:0] s, logic a, logic b);
        if (m == 0) return ref_z(s, a, b);
        if (m == 1) return 1'b0;
        return ~ref_z(s, a, b);
    endfunction

    assign z1 = unit_z(mode1, sel1, x1, y1);
    assign z3 = unit_z(mode3, sel3, x3, y3);

    func_sweep #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sel(sel1), .x(x1), .y(y1), .z(z1),
        .busy(busy1), .done(done1), .err_count(err1), .fail_mask(mask1)
`ifdef FUNC_SWEEP_HALT_EN
        , .fail_sel(fail_sel1), .fail_xy(fail_xy1)
`endif
    );

    func_sweep #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .sel(sel3), .x(x3), .y(y3), .z(z3),
        .busy(busy3), .done(done3), .err_count(err3), .fail_mask(mask3)
`ifdef FUNC_SWEEP_HALT_EN
        , .fail_sel(fail_sel3), .fail_xy(fail_xy3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int len, input logic [6:0] e, input logic [15:0] m);
        exp_t t;
        t.len  = len;
        t.err  = e;
        t.mask = m;
        sb.push_back(t);
    endtask

    // Starts dut1 (edge E0), optionally re-pulses start at sweep cycle pulse_k, then checks the popped expectation at done.
    task automatic run_sweep1(input int pulse_k);
        exp_t e;
        int   k = 0;
        int   busy_cnt = 0;
        bit   got = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        while (k < 400 && !got) begin
            if (done1) begin
                got = 1;
            end else begin
                if (busy1) busy_cnt++;
                start1 = (k == pulse_k);
                tick();
                k++;
            end
        end
        start1 = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        if (!got) begin
            errors++;
            $display("FAIL done_timeout got no done in %0d cycles want done at %0d", k, e.len);
            return;
        end
        if (k !== e.len) begin
            errors++;
            $display("FAIL done_cycle got %0d want %0d", k, e.len);
        end
        checks++;
        if (busy_cnt !== e.len || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_window got %0d cycles (busy at done %b) want %0d cycles (0)", busy_cnt, busy1, e.len);
        end
        checks++;
        if (err1 !== e.err) begin
            errors++;
            $display("FAIL err_count got %0d want %0d", err1, e.err);
        end
        checks++;
        if (mask1 !== e.mask) begin
            errors++;
            $display("FAIL fail_mask got %h want %h", mask1, e.mask);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse got done %b busy %b want 0 0", done1, busy1);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start1 = 1'b1;
        start3 = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        start1 = 1'b0;
        checks++;
        if ({sel1, x1, y1, busy1, done1, err1, mask1} !== 30'd0) begin
            errors++;
            $display("FAIL reset_state got sel %h xy %b%b busy %b done %b err %0d mask %h want all 0",
                     sel1, x1, y1, busy1, done1, err1, mask1);
        end
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut3 got busy %b done %b want 0 0", busy3, done3);
        end
`ifdef FUNC_SWEEP_HALT_EN
        checks++;
        if (fail_sel1 !== 4'd0 || fail_xy1 !== 2'b00) begin
            errors++;
            $display("FAIL reset_fail_vec got %h %b want 0 00", fail_sel1, fail_xy1);
        end
`endif
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst got busy %b want 0", busy1);
        end
    endtask

    task automatic test_correct();
        mode1 = 0;
        push_exp(64, 7'd0, 16'h0000);
        run_sweep1(-1);
    endtask

`ifdef FUNC_SWEEP_HALT_EN
    task automatic test_halt();
        mode1 = 1;
        push_exp(8, 7'd1, 16'h0002);
        run_sweep1(-1);
        checks++;
        if (fail_sel1 !== 4'd1 || fail_xy1 !== 2'b11) begin
            errors++;
            $display("FAIL halt_fail_vec got sel %h xy %b want 1 11", fail_sel1, fail_xy1);
        end
        checks++;
        if (sel1 !== 4'd1 || {x1, y1} !== 2'b11) begin
            errors++;
            $display("FAIL halt_hold_vec got sel %h xy %b%b want 1 11", sel1, x1, y1);
        end
        mode1 = 0;
    endtask
`else
    task automatic test_tie0();
        mode1 = 1;
        push_exp(64, 7'd32, 16'hFFFE);
        run_sweep1(-1);
        checks++;
        if (sel1 !== 4'hF || {x1, y1} !== 2'b11) begin
            errors++;
            $display("FAIL final_vec_hold got sel %h xy %b%b want F 11", sel1, x1, y1);
        end
    endtask

    task automatic test_inverted();
        mode1 = 2;
        push_exp(64, 7'd64, 16'hFFFF);
        run_sweep1(-1);
        mode1 = 0;
        push_exp(64, 7'd0, 16'h0000);
        run_sweep1(-1);
    endtask
`endif

    task automatic test_settle3();
        exp_t       e;
        logic [5:0] v;
        int         k = 0;
        bit         got = 0;
        mode3 = 0;
        push_exp(192, 7'd0, 16'h0000);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        while (k < 400 && !got) begin
            if (done3) begin
                got = 1;
            end else begin
                if (k < 192) begin
                    v = 6'(k / 3);
                    checks++;
                    if (sel3 !== v[5:2] || {x3, y3} !== v[1:0] || busy3 !== 1'b1) begin
                        errors++;
                        $display("FAIL settle3_vec cycle %0d got sel %h xy %b%b busy %b want %h %b 1",
                                 k, sel3, x3, y3, busy3, v[5:2], v[1:0]);
                    end
                end
                tick();
                k++;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!got || k !== e.len) begin
            errors++;
            $display("FAIL settle3_done got cycle %0d (seen %b) want %0d", k, got, e.len);
        end
        checks++;
        if (err3 !== e.err || mask3 !== e.mask) begin
            errors++;
            $display("FAIL settle3_result got %0d %h want %0d %h", err3, mask3, e.err, e.mask);
        end
    endtask

    task automatic test_start_ignored();
        mode1 = 0;
        push_exp(64, 7'd0, 16'h0000);
        run_sweep1(10);
    endtask

    task automatic test_reset_mid();
        bit saw = 0;
        mode1 = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (err1 !== 7'd20 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_progress got err %0d busy %b want 20 1", err1, busy1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sel1, x1, y1, busy1, done1, err1, mask1} !== 30'd0) begin
            errors++;
            $display("FAIL reset_mid_state got sel %h xy %b%b busy %b done %b err %0d mask %h want all 0",
                     sel1, x1, y1, busy1, done1, err1, mask1);
        end
        for (int i = 0; i < 100; i++) begin
            if (done1 || busy1) saw = 1;
            tick();
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL reset_mid_no_done got activity 1 want 0");
        end
        mode1 = 0;
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        test_reset();
        test_correct();
`ifdef FUNC_SWEEP_HALT_EN
        test_halt();
`else
        test_tie0();
        test_inverted();
`endif
        test_settle3();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/func_sweep.md
Name: func_sweep

Overview:
- Self-checking stimulus/monitor stage wrapped around the 2-input programmable logic function unit.
- Drives the unit's 4-bit select and x/y inputs through all 16 functions × 4 input combinations and samples the unit's z output.
- Compares each sample against the truth table encoded by the select value and reports per-function pass/fail plus a total error count.
- Serves as the board-level self-test for the logic-function lab.

Parameters:
- SETTLE, default 1: cycles each vector is held before z is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a sweep; ignored unless in IDLE
- sel  output  4  function select driven to the function unit
- x  output  1  operand x driven to the function unit
- y  output  1  operand y driven to the function unit
- z  input  1  function unit result, combinational from sel/x/y
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- err_count  output  7  number of mismatching samples in the last sweep (0..64)
- fail_mask  output  16  bit n set if function n had at least one mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel=0, x=0, y=0, busy=0, done=0, err_count=0, fail_mask=0, settle counter=0.
- Reset mid-sweep: abandons the sweep immediately, with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - next state RUN; sel=0, {x,y}=00, settle counter=0.
  - err_count and fail_mask cleared; busy=1 from the cycle after E0.
- RUN, per cycle:
  - If the settle counter is below SETTLE-1, increment it.
  - Otherwise it is a sample edge: compare z with expected = sel[3 - {x,y}], where {x,y} is a 2-bit index with x as MSB.
    - Index 00 maps to sel[3], 01 to sel[2], 10 to sel[1], 11 to sel[0].
  - On mismatch: err_count += 1 and fail_mask[sel] set.
  - Then clear the settle counter and advance {x,y} 00→01→10→11.
  - After 11, {x,y} wraps to 00 and sel increments.
  - At the sample edge of sel=15, {x,y}=11, go to DONE; sel/x/y hold their final values.
- Sweep length: exactly 64×SETTLE sample-window cycles. The last sample edge is E0 + 64×SETTLE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - err_count and fail_mask hold until the next accepted start or reset.
  - sel/x/y hold in IDLE.
- start while RUN or DONE is ignored, with no restart.
- start coincident with rst: reset wins.
- err_count cannot overflow (max 64 fits in 7 bits); no saturation logic needed.
- z is sampled only at sample edges; z glitches between sample edges are irrelevant.

Optional Feature:
- Macro: FUNC_SWEEP_HALT_EN.
- Defined:
  - Adds output fail_sel (4 bits, reset 0) and output fail_xy (2 bits, reset 0).
  - On the first mismatch, the FSM goes straight to DONE on that sample edge.
  - err_count=1, fail_mask has the single bit set, and fail_sel/fail_xy capture the failing vector.
  - sel/x/y hold at the failing vector.
- Undefined: no extra ports; the full sweep always runs and all mismatches are counted.

Test Plan:
- Reset, then start with a correct function unit attached, SETTLE=1 → busy for 64 cycles, done pulse at cycle 65 after E0, err_count=0, fail_mask=16'h0000.
- z tied to 0 → err_count=32 (total ones across all truth tables), fail_mask=16'hFFFE.
- z = inverted correct output → err_count=64, fail_mask=16'hFFFF; then a second start with a correct unit clears these to 0/16'h0000.
- SETTLE=3, correct unit → done exactly 192 cycles after E0 plus one; each sel/x/y vector observed stable for 3 cycles.
- start pulsed again at sweep cycle 10 → ignored, with total sweep length unchanged. rst asserted at cycle 20 → all outputs reset next edge, no done pulse.
- With FUNC_SWEEP_HALT_EN and z tied to 0 → halts at sel=1, {x,y}=11: done after 8 sample edges, err_count=1, fail_mask=16'h0002, fail_sel=1, fail_xy=2'b11.
